serial_nibble_receiver: RTL
===========================

# serial_nibble_receiver

Serial-to-parallel receive stage that consumes the LSB-first bit stream shifted out of the 4-bit parallel-load shift register (its bit-0 output). It frames each word with a start and stop bit and reassembles it into a parallel word. It presents the word on a valid/ready output port and flags framing errors and overruns. Bit timing is set by an external strobe, so the block runs entirely in the shared clock domain.

## Interface
- WIDTH, 4, data bits per frame (≥2).
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- sin  input  1  serial data bit; line idles at 1.
- sin_en  input  1  bit strobe; sin is sampled only in cycles where sin_en=1.
- dout  output  WIDTH  received word; dout[0] is the first data bit received.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid=1 and dout_ready=1.
- framing_err  output  1  one-cycle pulse: stop bit sampled as 0.
- overrun  output  1  one-cycle pulse: completed frame dropped because the holding register was full.
- parity_err  output  1  one-cycle pulse: parity mismatch. Constant 0 when parity is compiled out.

## Operation
- Frame on sin, one bit per strobe: start (0), WIDTH data bits LSB-first, [parity bit], stop (1).
- FSM states: IDLE, DATA, PARITY (present only with PARITY_EN), STOP.
- IDLE: on a strobe with sin=0, go to DATA with bit counter = 0. A strobe with sin=1 stays in IDLE.
- DATA: each strobe shifts the assembly register right and inserts sin at the MSB, then increments the counter. After the WIDTH-th data strobe, go to PARITY if enabled, else STOP.
- PARITY: one strobe samples the parity bit, then go to STOP. A mismatch is recorded for the frame.
- STOP: one strobe samples the stop bit, then always return to IDLE.
  - sin=1 and no parity mismatch: the frame is complete and is delivered to the holding register.
  - sin=0: framing_err pulses and the word is discarded.
  - Parity mismatch (with sin=1): parity_err pulses and the word is discarded.
  - A framing error takes precedence; only framing_err pulses.
- Holding register: a completed frame loads dout and sets dout_valid, provided the register is empty or is handshaking in the same cycle.
- Full holding register: if dout_valid=1 and dout_ready=0 when a frame completes, the new word is dropped, dout is unchanged, and overrun pulses.
- Handshake: dout_valid clears on dout_valid & dout_ready unless a new frame loads in that same cycle; in that case dout_valid stays 1 and dout takes the new word.
- dout is stable while dout_valid=1 and dout_ready=0.
- Cycles with sin_en=0 leave all FSM and assembly state unchanged.

## Timing
- Reset values: state IDLE, counter 0, dout=0, dout_valid=0, framing_err=0, overrun=0, parity_err=0.
- rst has priority over all other inputs. Reset mid-frame abandons the partial word and does not pulse any error flag.
- Latency: dout_valid and the new dout appear on the rising edge at the end of the cycle in which the stop-bit strobe is sampled, i.e. one clock after the strobe cycle.
- Error pulses are registered and aligned to the same edge as dout_valid would be.
- Back-to-back frames: a start bit is accepted on the strobe immediately after the stop strobe. No idle bit is required.
- sin_en may be asserted every cycle. The minimum frame length is WIDTH+2 strobes (WIDTH+3 with parity).

## Configuration
- PARITY_EN defined: a PARITY state is inserted after the data bits. The expected bit is even parity (XOR of the data bits) and a mismatch drives parity_err as described above.
- PARITY_EN undefined: no PARITY state, frames are WIDTH+2 bits long, and parity_err is tied to 0.

## Test plan
- Reset/idle: assert rst for 2 cycles with sin=1 and sin_en=1 -> all outputs 0, no frame started.
- Basic receive: strobe 0,1,0,1,1,1 (start, data 1,0,1,1, stop) with WIDTH=4, dout_ready=0 -> dout=4'b1101, dout_valid=1 one clock after the stop strobe, held until dout_ready=1.
- Framing error: a frame with stop bit 0 -> framing_err pulses for one cycle, dout_valid stays 0, FSM back in IDLE.
- Overrun: receive 4'hA and hold dout_ready=0, then receive 4'h5 -> overrun pulses, dout stays 4'hA. Assert dout_ready in the cycle a third frame (4'h3) completes -> dout=4'h3, dout_valid stays 1, no overrun.
- Mid-frame reset: assert rst after 2 data bits, then send a full frame for 4'h6 -> dout=4'h6, no error pulses.
- PARITY_EN: data 4'b0111 with parity bit 1 -> accepted. The same data with parity bit 0 -> parity_err pulses and dout_valid stays 0.

Source files
------------

// File: rtl/serial_nibble_receiver_if.sv
// ---------------------------------------------------------------------------
// serial_nibble_receiver_if
//   Bundles the serial input, the parallel valid/ready output port and the
//   error pulses of the serial nibble receiver.
//
//   Parameter
//     WIDTH       data bits per frame
//   Signals
//     sin         serial data bit, line idles at 1
//     sin_en      bit strobe, sin is sampled only when 1
//     dout        received word, dout[0] is the first data bit received
//     dout_valid  dout holds an unconsumed word
//     dout_ready  consumer accepts dout when dout_valid & dout_ready
//     framing_err one-cycle pulse, stop bit sampled as 0
//     overrun     one-cycle pulse, completed frame dropped (holding full)
//     parity_err  one-cycle pulse, parity mismatch (0 without PARITY_EN)
//   Modports
//     master      the receiver itself (drives the word and the flags)
//     slave       the environment (drives the serial line and dout_ready)
// ---------------------------------------------------------------------------
interface serial_nibble_receiver_if #(
    parameter int WIDTH = 4
);
    logic             sin;
    logic             sin_en;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             framing_err;
    logic             overrun;
    logic             parity_err;

    modport master (
        input  sin,
        input  sin_en,
        input  dout_ready,
        output dout,
        output dout_valid,
        output framing_err,
        output overrun,
        output parity_err
    );

    modport slave (
        output sin,
        output sin_en,
        output dout_ready,
        input  dout,
        input  dout_valid,
        input  framing_err,
        input  overrun,
        input  parity_err
    );
endinterface

// File: rtl/serial_nibble_receiver.sv
// ---------------------------------------------------------------------------
// serial_nibble_receiver
//   Serial-to-parallel receive stage. Frames of the form
//   start(0), WIDTH data bits LSB-first, [even parity bit], stop(1) are
//   sampled one bit per sin_en strobe, reassembled, and presented on a
//   valid/ready port. Framing errors, parity errors and overruns are
//   reported as registered one-cycle pulses.
//
//   Optional feature macro: PARITY_EN
//     defined   -> a parity bit (XOR of the data bits) follows the data
//     undefined -> no parity bit, parity_err tied to 0
//
//   Ports
//     clk   system clock, rising edge
//     rst   synchronous active-high reset
//     bus   serial_nibble_receiver_if.master (see interface header)
// ---------------------------------------------------------------------------
module serial_nibble_receiver #(
    parameter int WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    serial_nibble_receiver_if.master  bus
);

    localparam int                 CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
`ifdef PARITY_EN
        PARITY = 2'd2,
`endif
        STOP   = 2'd3
    } state_t;

`ifdef PARITY_EN
    // Even parity: the transmitted bit equals the XOR of the data bits.
    function automatic logic even_parity(input logic [WIDTH-1:0] data);
        return ^data;
    endfunction
`endif

    // Frame assembly state
    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] shift_s;
`ifdef PARITY_EN
    logic             par_bad_r;
    logic             par_bad_s;
    logic             parity_err_r;
    logic             parity_err_s;
`endif

    // Stop-strobe outcome
    logic             frame_ok_s;
    logic             frame_bad_stop_s;

    // Holding register and flags
    logic [WIDTH-1:0] dout_r;
    logic [WIDTH-1:0] dout_s;
    logic             dout_valid_r;
    logic             dout_valid_s;
    logic             framing_err_r;
    logic             framing_err_s;
    logic             overrun_r;
    logic             overrun_s;

    // Next-state logic: the FSM and the assembly register only move on strobes.
    always_comb begin
        state_s          = state_r;
        cnt_s            = cnt_r;
        shift_s          = shift_r;
        frame_ok_s       = 1'b0;
        frame_bad_stop_s = 1'b0;
`ifdef PARITY_EN
        par_bad_s        = par_bad_r;
        parity_err_s     = 1'b0;
`endif
        if (bus.sin_en) begin
            case (state_r)
                IDLE: begin
                    if (bus.sin == 1'b0) begin
                        state_s = DATA;
                        cnt_s   = {CNT_W{1'b0}};
`ifdef PARITY_EN
                        par_bad_s = 1'b0;
`endif
                    end else begin
                        state_s = IDLE;
                    end
                end
                DATA: begin
                    // LSB arrives first, so shifting right leaves it in bit 0.
                    shift_s = {bus.sin, shift_r[WIDTH-1:1]};
                    if (cnt_r == LAST_BIT) begin
                        cnt_s = {CNT_W{1'b0}};
`ifdef PARITY_EN
                        state_s = PARITY;
`else
                        state_s = STOP;
`endif
                    end else begin
                        cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
`ifdef PARITY_EN
                PARITY: begin
                    par_bad_s = (bus.sin != even_parity(shift_r));
                    state_s   = STOP;
                end
`endif
                STOP: begin
                    state_s = IDLE;
                    // A bad stop bit wins over a parity mismatch.
                    if (bus.sin == 1'b0) begin
                        frame_bad_stop_s = 1'b1;
`ifdef PARITY_EN
                    end else if (par_bad_r) begin
                        parity_err_s = 1'b1;
`endif
                    end else begin
                        frame_ok_s = 1'b1;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Holding register: load when empty or draining this cycle, else overrun.
    always_comb begin
        dout_s        = dout_r;
        dout_valid_s  = dout_valid_r;
        overrun_s     = 1'b0;
        framing_err_s = frame_bad_stop_s;
        if (frame_ok_s && (!dout_valid_r || bus.dout_ready)) begin
            dout_s       = shift_r;
            dout_valid_s = 1'b1;
        end else if (frame_ok_s) begin
            overrun_s = 1'b1;
        end else if (dout_valid_r && bus.dout_ready) begin
            dout_valid_s = 1'b0;
        end else begin
            dout_valid_s = dout_valid_r;
        end
    end

    // FSM and assembly registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            shift_r <= {WIDTH{1'b0}};
`ifdef PARITY_EN
            par_bad_r <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            shift_r <= shift_s;
`ifdef PARITY_EN
            par_bad_r <= par_bad_s;
`endif
        end
    end

    // Output registers: word, valid and the error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_r        <= {WIDTH{1'b0}};
            dout_valid_r  <= 1'b0;
            framing_err_r <= 1'b0;
            overrun_r     <= 1'b0;
`ifdef PARITY_EN
            parity_err_r  <= 1'b0;
`endif
        end else begin
            dout_r        <= dout_s;
            dout_valid_r  <= dout_valid_s;
            framing_err_r <= framing_err_s;
            overrun_r     <= overrun_s;
`ifdef PARITY_EN
            parity_err_r  <= parity_err_s;
`endif
        end
    end

    assign bus.dout        = dout_r;
    assign bus.dout_valid  = dout_valid_r;
    assign bus.framing_err = framing_err_r;
    assign bus.overrun     = overrun_r;
`ifdef PARITY_EN
    assign bus.parity_err  = parity_err_r;
`else
    assign bus.parity_err  = 1'b0;
`endif

endmodule
